// File: rtl/k285_defs.sv
// Shared constants for the 8b10b receive path: code-group width, K28.5 patterns,
// aligner state encoding and the error-counter saturation value.
package k285_defs;

  localparam int ANCHO = 10;

  localparam logic [ANCHO-1:0] K285_RDN = 10'b0011111010;
  localparam logic [ANCHO-1:0] K285_RDP = 10'b1100000101;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

endpackage

// File: rtl/k285_bit_counter.sv
// Mod-ANCHO bit position counter; loads 1 on a comma pulse, zero latency flags.
// Holds while enb is low; no backpressure of its own.
module k285_bit_counter
  import k285_defs::*;
#(
  parameter int WIDTH = ANCHO
) (
  input  logic clk,
  input  logic rst,
  input  logic enb,
  input  logic load,
  output logic at_first,
  output logic at_last
);

  logic [3:0] bit_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (enb) begin
      if (load) begin
        bit_cnt <= 4'd1;
      end else if (at_last) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  assign at_first = (bit_cnt == 4'd0);
  assign at_last  = (bit_cnt == 4'(WIDTH - 1));

endmodule

// File: rtl/k285_word_aligner.sv
// Frames the serial stream into code groups on K28.5 boundaries; strobe 1 cycle after last bit, enb stalls everything.
// K285_ALIGNER_STRIP_COMMA_EN: comma words flag esComa but raise no dataValid.
module k285_word_aligner #(
  parameter int                   ANCHO       = k285_defs::ANCHO,
  parameter logic [ANCHO-1:0]     valork285   = k285_defs::K285_RDN,
  parameter logic [ANCHO-1:0]     valork285p  = k285_defs::K285_RDP,
  parameter int                   MAXPALABRAS = 64,
  parameter int                   PwrC        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             entrada,
  input  logic             esk285,
  output logic [ANCHO-1:0] dataOut,
  output logic             dataValid,
  output logic             esComa,
  output logic             alineado,
  output logic [7:0]       errAlineo
);

  import k285_defs::*;

  if (MAXPALABRAS < 1 || MAXPALABRAS > 255 || PwrC < 0) begin : g_bad_param
    $error("k285_word_aligner: MAXPALABRAS must be 1..255 and PwrC non-negative");
  end

  logic [ANCHO-2:0] shreg;
  logic [ANCHO-1:0] word;
  logic             at_first;
  logic             at_last;
  state_t           state;
  state_t           state_nxt;
  logic [7:0]       word_cnt;
  logic [7:0]       word_cnt_nxt;
  logic             word_done;
  logic             is_comma;
  logic             phase_err;
  logic             timeout;
  logic             strobe;

  k285_bit_counter #(
    .WIDTH (ANCHO)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .load     (esk285),
    .at_first (at_first),
    .at_last  (at_last)
  );

  assign word     = {shreg, entrada};
  assign is_comma = (word == valork285) || (word == valork285p);

`ifdef K285_ALIGNER_STRIP_COMMA_EN
  assign strobe = word_done && !is_comma;
`else
  assign strobe = word_done;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
    end else if (enb) begin
      state <= state_nxt;
    end
  end

  // A comma pulse always restarts the word and the no-comma run, even on a timeout edge.
  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    word_done    = 1'b0;
    phase_err    = 1'b0;
    timeout      = 1'b0;
    case (state)
      HUNT: begin
        if (esk285) begin
          state_nxt    = SYNC;
          word_cnt_nxt = '0;
        end
      end
      SYNC: begin
        if (esk285) begin
          phase_err    = !at_first;
          word_cnt_nxt = '0;
        end else if (at_last) begin
          word_done = 1'b1;
          if (is_comma) begin
            word_cnt_nxt = '0;
          end else if (word_cnt + 8'd1 == 8'(MAXPALABRAS)) begin
            timeout      = 1'b1;
            state_nxt    = HUNT;
            word_cnt_nxt = '0;
          end else begin
            word_cnt_nxt = word_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      word_cnt  <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      esComa    <= 1'b0;
      alineado  <= 1'b0;
      errAlineo <= '0;
    end else begin
      dataValid <= 1'b0;
      esComa    <= 1'b0;
      if (enb) begin
        shreg     <= word[ANCHO-2:0];
        word_cnt  <= word_cnt_nxt;
        alineado  <= (state_nxt == SYNC);
        dataValid <= strobe;
        if (word_done) begin
          dataOut <= word;
          esComa  <= is_comma;
        end
        if ((phase_err || timeout) && errAlineo != ERR_SAT) begin
          errAlineo <= errAlineo + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_k285_word_aligner.sv
// Randomized scoreboard bench for k285_word_aligner against a bit-queue reference model.
module tb_k285_word_aligner;

  localparam int         MAXW  = 4;
  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       entrada = 1'b0;
  logic       esk285 = 1'b0;
  logic [9:0] dataOut;
  logic       dataValid;
  logic       esComa;
  logic       alineado;
  logic [7:0] errAlineo;

  always #5 clk = ~clk;

  k285_word_aligner #(
    .MAXPALABRAS (MAXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .entrada   (entrada),
    .esk285    (esk285),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .esComa    (esComa),
    .alineado  (alineado),
    .errAlineo (errAlineo)
  );

  typedef struct {
    logic [9:0] d;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   strobe_cyc[$];

  // Reference model: bits collected since the last boundary, words seen without a comma.
  bit   m_sync = 1'b0;
  int   m_wc = 0;
  int   m_err = 0;
  bit   m_bits[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_step(input bit b, input bit k);
    logic [9:0] w;
    bit         com;
    if (k) begin
      if (m_sync && m_bits.size() != 0) m_err = sat_inc(m_err);
      m_sync = 1'b1;
      m_wc   = 0;
      m_bits.delete();
      m_bits.push_back(b);
    end else if (m_sync) begin
      m_bits.push_back(b);
      if (m_bits.size() == 10) begin
        w = '0;
        for (int i = 0; i < 10; i++) w = {w[8:0], m_bits[i]};
        com = (w == K_RDN) || (w == K_RDP);
`ifdef K285_ALIGNER_STRIP_COMMA_EN
        if (!com) sb.push_back('{w, com});
`else
        sb.push_back('{w, com});
`endif
        if (com) m_wc = 0;
        else m_wc++;
        if (m_wc == MAXW) begin
          m_sync = 1'b0;
          m_wc   = 0;
          m_err  = sat_inc(m_err);
        end
        m_bits.delete();
      end
    end
  endtask

  task automatic drive(input bit b, input bit k, input bit e);
    @(negedge clk);
    entrada = b;
    esk285  = k;
    enb     = e;
    if (e && rst) model_step(b, k);
  endtask

  task automatic send_word(input logic [9:0] w, input bit k);
    for (int i = 9; i >= 0; i--) drive(w[i], (i == 9) && k, 1'b1);
  endtask

  task automatic send_word_stall(input logic [9:0] w, input bit k, input int at, input int n);
    for (int i = 9; i >= 0; i--) begin
      if (9 - i == at) begin
        for (int s = 0; s < n; s++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      drive(w[i], (i == 9) && k, 1'b1);
    end
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    if (w == K_RDN || w == K_RDP) w[0] = ~w[0];
    return w;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    m_sync = 1'b0;
    m_wc   = 0;
    m_err  = 0;
    m_bits.delete();
    sb.delete();
    #1;
    chk("rst_dataOut", 32'(dataOut), 32'h0);
    chk("rst_dataValid", 32'(dataValid), 32'h0);
    chk("rst_esComa", 32'(esComa), 32'h0);
    chk("rst_alineado", 32'(alineado), 32'h0);
    chk("rst_errAlineo", 32'(errAlineo), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every strobe and tracks the status outputs each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (dataValid) begin
        strobe_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: dataOut=%h with no word expected (t=%0t)", dataOut, $time);
        end else begin
          e = sb.pop_front();
          chk("dataOut", 32'(dataOut), 32'(e.d));
          chk("esComa", 32'(esComa), 32'(e.c));
        end
      end
`ifndef K285_ALIGNER_STRIP_COMMA_EN
      else begin
        chk("esComa_idle", 32'(esComa), 32'h0);
      end
`endif
      chk("alineado", 32'(alineado), 32'(m_sync));
      chk("errAlineo", 32'(errAlineo), 32'(m_err));
    end
  end

  initial begin
    int r;
    #1;
    chk("init_dataOut", 32'(dataOut), 32'h0);
    chk("init_dataValid", 32'(dataValid), 32'h0);
    chk("init_alineado", 32'(alineado), 32'h0);
    chk("init_errAlineo", 32'(errAlineo), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // No comma: random bits never frame a word.
    for (int i = 0; i < 100; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("hunt_alineado", 32'(alineado), 32'h0);

    // Two data words after a comma, exactly ten cycles apart.
    strobe_cyc.delete();
    send_word(10'h2AA, 1'b1);
    send_word(10'h155, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("strobe_count", 32'(strobe_cyc.size()), 32'd2);
    if (strobe_cyc.size() == 2) chk("strobe_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd10);

    // RD+1 comma word, then a phase error at bit 4.
    send_word(K_RDP, 1'b1);
    send_word(10'h0F3, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    send_word(10'h1C7, 1'b1);
    send_word(10'h03C, 1'b0);

    // Timeout after MAXW non-comma words.
    do_reset();
    send_word(10'h2AA, 1'b1);
    for (int i = 0; i < MAXW - 1; i++) send_word(rand_data(), 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("timeout_alineado", 32'(alineado), 32'h0);
    chk("timeout_errAlineo", 32'(errAlineo), 32'd1);

    // Forced phase errors saturate the counter.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1, 1'b1);
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("sat_errAlineo", 32'(errAlineo), 32'd255);

    // Enable stall mid-word, then reset mid-word.
    do_reset();
    send_word(10'h2AA, 1'b1);
    send_word_stall(10'h3B5, 1'b0, 5, 7);
    for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 30; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
    chk("post_rst_alineado", 32'(alineado), 32'h0);

    // Random mix of boundaries, data, commas, partial words and stalls.
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1: send_word(10'($urandom), 1'b1);
        2, 3, 4, 5: send_word(10'($urandom), 1'b0);
        6: begin
          int len;
          len = int'($urandom_range(1, 9));
          for (int i = 0; i < len; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        7: begin
          int len;
          len = int'($urandom_range(1, 5));
          for (int i = 0; i < len; i++) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        8: send_word($urandom_range(0, 1) ? K_RDN : K_RDP, 1'($urandom_range(0, 1)));
        default: send_word_stall(10'($urandom), 1'($urandom_range(0, 1)),
                                 int'($urandom_range(0, 9)), int'($urandom_range(1, 7)));
      endcase
    end

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
